// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the PC/fetch controller and the VLUT.
// State encoding plus the VLUT row constants.
package pc_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [2:0] ROW_ZERO   = 3'd0;
    localparam logic [2:0] ROW_ONE    = 3'd1;
    localparam logic [2:0] ROW_THIRTY = 3'd2;
    localparam logic [2:0] ROW_SIXTY  = 3'd3;

    localparam logic [7:0] VAL_ZERO   = 8'd0;
    localparam logic [7:0] VAL_ONE    = 8'd1;
    localparam logic [7:0] VAL_THIRTY = 8'd30;
    localparam logic [7:0] VAL_SIXTY  = 8'd60;

endpackage

// File: rtl/pc_fetch_ctrl_next_calc.sv
// Combinational next-PC selection: increment, absolute or relative jump.
// The relative path sign-extends the LUT value and wraps modulo 2^PC_W.
module pc_next_calc
#(
    parameter int PC_W  = 10,
    parameter int LUT_W = 8
)
(
    input  logic [PC_W-1:0]  i_pc,
    input  logic [LUT_W-1:0] i_lut_value,
    input  logic             i_branch,
    input  logic             i_rel,
    output logic [PC_W-1:0]  o_next_pc
);

    logic [PC_W-1:0] w_zext;
    logic [PC_W-1:0] w_sext;

    assign w_zext = PC_W'(i_lut_value);
    assign w_sext = PC_W'($signed(i_lut_value));

    always_comb begin
        o_next_pc = i_pc + 1'b1;
        if (i_branch) begin
            if (i_rel) begin
                o_next_pc = i_pc + w_sext;
            end else begin
                o_next_pc = w_zext;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter / fetch controller with IDLE/RUN/HALT sequencing
// and a saturating taken-branch counter.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int LUT_W = 8,
    parameter int ROW_W = 3,
    parameter int CNT_W = 16
)
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             JumpRel,
    input  logic [ROW_W-1:0] JumpRow,
    input  logic             HaltReq,
    output logic [ROW_W-1:0] LutRow,
    input  logic [LUT_W-1:0] LutValue,
    output logic [PC_W-1:0]  ProgCounter,
    output logic             InstValid,
    output logic             Done,
    output logic [CNT_W-1:0] BranchCount
);

    if (LUT_W > PC_W) begin : g_bad_width
        $error("pc_fetch_ctrl: LUT_W must not exceed PC_W");
    end

    pc_state_t        r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_count;
    logic             r_inst_valid;
    logic             r_done;
    logic [PC_W-1:0]  w_next_pc;

    assign LutRow = JumpRow;

    pc_next_calc #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W)
    ) u_next (
        .i_pc        (r_pc),
        .i_lut_value (LutValue),
        .i_branch    (BranchEn),
        .i_rel       (JumpRel),
        .o_next_pc   (w_next_pc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_count      <= '0;
            r_inst_valid <= 1'b0;
            r_done       <= 1'b0;
        end else if (Start) begin
            r_state      <= RUN;
            r_pc         <= StartAddr;
            r_count      <= '0;
            r_inst_valid <= 1'b1;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (Stall) begin
                        r_state <= RUN;
                    end else if (HaltReq) begin
                        // halt wins over a same-cycle branch: PC and count hold
                        r_state      <= HALT;
                        r_inst_valid <= 1'b0;
                        r_done       <= 1'b1;
                    end else begin
                        r_pc <= w_next_pc;
                        if (BranchEn && (r_count != {CNT_W{1'b1}})) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                end
                HALT: r_state <= HALT;
                default: r_state <= r_state;
            endcase
        end
    end

    assign ProgCounter = r_pc;
    assign InstValid   = r_inst_valid;
    assign Done        = r_done;
    assign BranchCount = r_count;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized self-checking bench for pc_fetch_ctrl against a
// behavioural model, plus hand-computed directed expectations.
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 10;
    localparam int LUT_W = 8;
    localparam int ROW_W = 3;
    localparam int CNT_W = 4;
    localparam int PMOD  = 1 << PC_W;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clk = 1'b0;
    logic             Reset_n = 1'b0;
    logic             Start = 1'b0;
    logic [PC_W-1:0]  StartAddr = '0;
    logic             Stall = 1'b0;
    logic             BranchEn = 1'b0;
    logic             JumpRel = 1'b0;
    logic [ROW_W-1:0] JumpRow = '0;
    logic             HaltReq = 1'b0;
    logic [ROW_W-1:0] LutRow;
    logic [LUT_W-1:0] LutValue;
    logic [PC_W-1:0]  ProgCounter;
    logic             InstValid;
    logic             Done;
    logic [CNT_W-1:0] BranchCount;

    logic [LUT_W-1:0] lut [8];

    int n_tests = 0;
    int n_fail  = 0;

    // model state: 0 idle, 1 run, 2 halt
    int m_st  = 0;
    int m_pc  = 0;
    int m_cnt = 0;

    always #5 Clk = ~Clk;

    assign LutValue = lut[LutRow];

    pc_fetch_ctrl #(
        .PC_W  (PC_W),
        .LUT_W (LUT_W),
        .ROW_W (ROW_W),
        .CNT_W (CNT_W)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .StartAddr   (StartAddr),
        .Stall       (Stall),
        .BranchEn    (BranchEn),
        .JumpRel     (JumpRel),
        .JumpRow     (JumpRow),
        .HaltReq     (HaltReq),
        .LutRow      (LutRow),
        .LutValue    (LutValue),
        .ProgCounter (ProgCounter),
        .InstValid   (InstValid),
        .Done        (Done),
        .BranchCount (BranchCount)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h",
                     nm, $time, act, exp);
        end
    endtask

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_st  = 0;
            m_pc  = 0;
            m_cnt = 0;
        end else if (Start) begin
            m_st  = 1;
            m_pc  = int'(StartAddr);
            m_cnt = 0;
        end else if (m_st == 1 && !Stall) begin
            if (HaltReq) begin
                m_st = 2;
            end else if (BranchEn) begin
                int v;
                v = int'(lut[JumpRow]);
                if (JumpRel) begin
                    if (v >= 128) v = v - 256;
                    m_pc = ((m_pc + v) % PMOD + PMOD) % PMOD;
                end else begin
                    m_pc = v;
                end
                if (m_cnt < CMAX) m_cnt = m_cnt + 1;
            end else begin
                m_pc = (m_pc + 1) % PMOD;
            end
        end
    end

    always @(posedge Clk) begin
        #1;
        chk("pc",     int'(ProgCounter), m_pc);
        chk("valid",  int'(InstValid),   int'(m_st == 1));
        chk("done",   int'(Done),        int'(m_st == 2));
        chk("count",  int'(BranchCount), m_cnt);
        chk("lutrow", int'(LutRow),      int'(JumpRow));
    end

    task automatic step(input logic s, input int a, input logic st,
                        input logic br, input logic rel,
                        input int row, input logic h);
        @(negedge Clk);
        Start     = s;
        StartAddr = PC_W'(a);
        Stall     = st;
        BranchEn  = br;
        JumpRel   = rel;
        JumpRow   = ROW_W'(row);
        HaltReq   = h;
        @(posedge Clk);
        #2;
    endtask

    task automatic lit(input string nm, input int pc, input int cnt,
                       input int v, input int d);
        chk({nm, ".pc"},    int'(ProgCounter), pc);
        chk({nm, ".count"}, int'(BranchCount), cnt);
        chk({nm, ".valid"}, int'(InstValid),   v);
        chk({nm, ".done"},  int'(Done),        d);
    endtask

    initial begin
        lut[0] = 8'd0;
        lut[1] = 8'd1;
        lut[2] = 8'd30;
        lut[3] = 8'd60;
        lut[4] = 8'hFE;
        lut[5] = 8'h80;
        lut[6] = 8'h7F;
        lut[7] = 8'hF0;

        #1;
        lit("reset", 0, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step(0, 0, 0, 1, 0, 3, 0);
        lit("idle_hold", 0, 0, 0, 0);

        step(1, 'h3FE, 0, 0, 0, 0, 0);
        lit("start_3fe", 'h3FE, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("inc_3ff", 'h3FF, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("wrap_000", 'h000, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        lit("inc_001", 'h001, 0, 1, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);
        lit("at_005", 'h005, 0, 1, 0);

        @(negedge Clk);
        #1 Reset_n = 1'b0;
        #1 lit("midrun_reset", 0, 0, 0, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        step(1, 'h010, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 3, 0);
        lit("abs_sixty", 'h03C, 1, 1, 0);

        step(1, 'h010, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 4, 0);
        lit("rel_m2", 'h00E, 1, 1, 0);
        step(1, 'h001, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 4, 0);
        lit("rel_wrap", 'h3FF, 1, 1, 0);

        step(1, 'h020, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 3, 0);
        lit("stall", 'h020, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        lit("abs_one", 'h001, 1, 1, 0);

        step(0, 0, 0, 1, 0, 3, 1);
        lit("halt", 'h001, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 7)), 1'($urandom));
            lit("halt_hold", 'h001, 1, 0, 1);
        end
        step(1, 'h100, 0, 0, 0, 0, 0);
        lit("restart", 'h100, 0, 1, 0);

        for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, 2, 0);
        lit("saturate", 30, CMAX, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            Start     = ($urandom_range(0, 39) == 0);
            StartAddr = PC_W'($urandom);
            Stall     = ($urandom_range(0, 4) == 0);
            BranchEn  = ($urandom_range(0, 2) == 0);
            JumpRel   = 1'($urandom);
            JumpRow   = ROW_W'($urandom);
            HaltReq   = ($urandom_range(0, 29) == 0);
            if (i % 997 == 500) begin
                #1 Reset_n = 1'b0;
                #2 Reset_n = 1'b1;
            end
        end
        @(negedge Clk);
        Start    = 1'b0;
        BranchEn = 1'b0;
        HaltReq  = 1'b0;
        Stall    = 1'b0;
        @(posedge Clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
